// File: rtl/vc_arb_demux.sv
// vc_arb_demux
//
// Purpose:
//   Takes words popped from two virtual channels (VC0, VC1). Each channel
//   has its own 4-entry holding queue (HQ0, HQ1). The heads of the two
//   queues compete for a single grant per cycle. The granted word is
//   steered to destination D0 or D1 by bit DEST_BIT of the word. It is
//   presented one cycle later as a registered push strobe plus data.
//
// Ports:
//   clk           - sole clock, rising edge
//   reset         - synchronous, active-high reset
//   valid_vc0/1   - a word is present on data_vc0/1 this cycle
//   data_vc0/1    - words popped from VC0 / VC1
//   d0_full/d1_full - destination FIFO cannot accept a push this cycle
//   push_d0/d1    - registered destination push strobes
//   data_d0/d1    - registered destination data (held while push is low)
//   pause_hold    - throttle to the upstream pop stage (either queue >= 2)
//   overflow_err  - sticky flag: a word arrived at a full queue and was dropped
//
// Configuration macro:
//   VC_RR_ARB_EN - when defined, round-robin arbitration between the
//                  two queue heads using a 1-bit last-grant register.
//                  When undefined, VC0 has strict priority.

module vc_arb_demux #(
  parameter int BW       = 6,
  parameter int DEST_BIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_vc0,
  input  logic          valid_vc1,
  input  logic [BW-1:0] data_vc0,
  input  logic [BW-1:0] data_vc1,
  input  logic          d0_full,
  input  logic          d1_full,
  output logic          push_d0,
  output logic          push_d1,
  output logic [BW-1:0] data_d0,
  output logic [BW-1:0] data_d1,
  output logic          pause_hold,
  output logic          overflow_err
);

  // Per-queue storage and bookkeeping, indexed by VC number.
  logic [BW-1:0] mem    [2][4];
  logic [2:0]    count  [2];
  logic [1:0]    rd_ptr [2];
  logic [1:0]    wr_ptr [2];

  logic [1:0]    valid_in;
  logic [BW-1:0] data_in [2];
  logic [BW-1:0] head    [2];
  logic [1:0]    to_d1;
  logic [1:0]    eligible;
  logic [1:0]    write_en;
  logic [1:0]    drop;
  logic [1:0]    grant;

  logic [BW-1:0] grant_word;
  logic          grant_to_d1;

  assign valid_in   = {valid_vc1, valid_vc0};
  assign data_in[0] = data_vc0;
  assign data_in[1] = data_vc1;

  // Head inspection and write/drop decisions.
  // A head is eligible only when its selected destination is not full.
  // A word arriving at a full queue is dropped, even if that queue pops
  // in the same cycle.
  always_comb begin
    for (int vc = 0; vc < 2; vc++) begin
      head[vc]     = mem[vc][rd_ptr[vc]];
      to_d1[vc]    = head[vc][DEST_BIT];
      eligible[vc] = (count[vc] != 3'd0) && !(to_d1[vc] ? d1_full : d0_full);
      write_en[vc] = valid_in[vc] && (count[vc] < 3'd4);
      drop[vc]     = valid_in[vc] && (count[vc] == 3'd4);
    end
  end

`ifdef VC_RR_ARB_EN
  // last_grant records the VC granted most recently (1 = VC1).
  // It resets to 1 so that VC0 wins the first contested cycle.
  logic last_grant;

  always_comb begin
    grant = eligible;
    if (&eligible) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end
`else
  // Strict priority: VC0 wins whenever both heads are eligible.
  always_comb begin
    grant = eligible;
    if (&eligible) begin
      grant = 2'b01;
    end
  end
`endif

  assign grant_word  = grant[1] ? head[1]  : head[0];
  assign grant_to_d1 = grant[1] ? to_d1[1] : to_d1[0];

  // Queue storage carries no reset. Stale entries are unreachable once
  // the pointers and counts are cleared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int vc = 0; vc < 2; vc++) begin
        if (write_en[vc]) begin
          mem[vc][wr_ptr[vc]] <= data_in[vc];
        end
      end
    end
  end

  // Pointer and count update.
  // A write and a pop of the same queue in the same cycle leave the count
  // unchanged. The pop always takes the old head.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int vc = 0; vc < 2; vc++) begin
        count[vc]  <= 3'd0;
        rd_ptr[vc] <= 2'd0;
        wr_ptr[vc] <= 2'd0;
      end
    end else begin
      for (int vc = 0; vc < 2; vc++) begin
        if (write_en[vc]) begin
          wr_ptr[vc] <= wr_ptr[vc] + 2'd1;
        end
        if (grant[vc]) begin
          rd_ptr[vc] <= rd_ptr[vc] + 2'd1;
        end
        count[vc] <= count[vc] + {2'b00, write_en[vc]} - {2'b00, grant[vc]};
      end
    end
  end

  // Registered destination side.
  // Data registers only load on a push, so they hold their last value
  // between pushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      push_d0      <= 1'b0;
      push_d1      <= 1'b0;
      data_d0      <= '0;
      data_d1      <= '0;
      overflow_err <= 1'b0;
    end else begin
      push_d0 <= (|grant) && !grant_to_d1;
      push_d1 <= (|grant) && grant_to_d1;
      if ((|grant) && !grant_to_d1) begin
        data_d0 <= grant_word;
      end
      if ((|grant) && grant_to_d1) begin
        data_d1 <= grant_word;
      end
      if (|drop) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // Throttle upstream at two entries.
  // This leaves room for words already in flight through a one-cycle
  // pop-to-valid pipeline.
  assign pause_hold = (count[0] >= 3'd2) || (count[1] >= 3'd2);

endmodule
